// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder: one shared digit adder, least significant digit first.
// Define BCD_DIGIT_CHECK_EN to build the invalid-digit (err) flag.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DIGITS-1:0][3:0] a_q, b_q, sum_q;
  logic                   c_q;
  logic [CW-1:0]          cnt_q;
  logic                   accept_c, last_c, carry_c;
  logic [4:0]             t_c;
  logic [3:0]             digit_c;

  assign accept_c = in_valid & in_ready;
  assign last_c   = (cnt_q == CW'(DIGITS - 1));
  assign sum      = sum_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ADD;
      ADD:     if (last_c) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared single-digit BCD adder on the digit selected by the counter
  always_comb begin
    t_c = 5'(a_q[cnt_q]) + 5'(b_q[cnt_q]) + 5'(c_q);
    if (t_c > 5'd9) begin
      digit_c = 4'(t_c + 5'd6);
      carry_c = 1'b1;
    end else begin
      digit_c = t_c[3:0];
      carry_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Operand capture and digit-serial accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout  <= 1'b0;
    end else if (state_q == IDLE && accept_c) begin
      a_q   <= a;
      b_q   <= b;
      c_q   <= cin;
      cnt_q <= '0;
    end else if (state_q == ADD) begin
      sum_q[cnt_q] <= digit_c;
      c_q          <= carry_c;
      cnt_q        <= cnt_q + CW'(1);
      if (last_c) cout <= carry_c;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_c;

  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[i] > 4'd9 || b_q[i] > 4'd9) bad_c = 1'b1;
    end
  end

  // Flag is latched together with the final digit, so it is valid in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state_q == ADD && last_c) err <= bad_c;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: digit-rule reference model,
// per-cycle compare process, and literal directed cases.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {err, cout, sum} using the decimal digit rule
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W-1:0] s;
    logic [3:0]   xd, yd;
    logic         e;
    int           c, t;
    s = '0;
    e = 1'b0;
    c = int'(ci);
    for (int d = 0; d < DIGITS; d++) begin
      xd = x[4*d +: 4];
      yd = y[4*d +: 4];
      t  = int'(xd) + int'(yd) + c;
      if (t > 9) begin
        s[4*d +: 4] = 4'((t + 6) % 16);
        c = 1;
      end else begin
        s[4*d +: 4] = 4'(t);
        c = 0;
      end
      if (xd > 4'd9 || yd > 4'd9) e = 1'b1;
    end
    if (!ERR_EXP) e = 1'b0;
    return {e, (c != 0), s};
  endfunction

  function automatic longint to_dec(input logic [W-1:0] x);
    longint r, m;
    r = 0;
    m = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r += longint'(x[4*d +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(input logic [W-1:0] x);
    for (int d = 0; d < DIGITS; d++) if (x[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rnd_bcd(input bit allow_bad);
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++)
      r[4*d +: 4] = 4'(allow_bad ? $urandom_range(0, 15) : $urandom_range(0, 9));
    return r;
  endfunction

  // Transaction-level model: expected handshake flags and result
  int             m_left;
  logic           m_ov, m_busy, m_ir;
  logic [W+1:0]   m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_ov   <= 1'b0;
      m_busy <= 1'b0;
      m_ir   <= 1'b0;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov   <= 1'b0;
        m_busy <= 1'b0;
        m_ir   <= 1'b1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_ov <= 1'b1;
    end else begin
      m_ir <= 1'b1;
      if (in_valid && m_ir) begin
        m_left <= DIGITS;
        m_busy <= 1'b1;
        m_ir   <= 1'b0;
        m_res  <= ref_add(a, b, cin);
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_busy);
      chk("in_ready", in_ready, m_ir);
      if (m_ov) begin
        chk("sum", sum, m_res[W-1:0]);
        chk("cout", cout, m_res[W]);
        chk("err", err, m_res[W+1]);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input int stall, output logic [W-1:0] rs, output logic rc,
                       output logic re, output int lat);
    int guard;
    guard = 0;
    rs = '0; rc = 1'b0; re = 1'b0; lat = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) begin
        in_valid = 1'($urandom);
        out_ready = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    rs = sum; rc = cout; re = err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_sum", sum, rs);
      chk("stall_cout", cout, rc);
      chk("stall_valid", out_valid, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs, ta, tb_;
    logic         rc, re, tc;
    int           lat;
    longint       de;

    // Model pins
    chk("ref_1234_5678", ref_add(16'h1234, 16'h5678, 1'b0), {2'b00, 16'h6912});
    chk("ref_9999_0001", ref_add(16'h9999, 16'h0001, 1'b0), {2'b01, 16'h0000});
    chk("ref_0000_cin", ref_add(16'h0000, 16'h0000, 1'b1), {2'b00, 16'h0001});
    chk("ref_000A", ref_add(16'h000A, 16'h0000, 1'b0), {ERR_EXP, 1'b0, 16'h0010});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op(16'h1234, 16'h5678, 1'b0, 3, rs, rc, re, lat);
    chk("d1_sum", rs, 16'h6912);
    chk("d1_cout", rc, 1'b0);
    chk("d1_latency", lat, DIGITS + 1);

    do_op(16'h9999, 16'h0001, 1'b0, 0, rs, rc, re, lat);
    chk("d2_sum", rs, 16'h0000);
    chk("d2_cout", rc, 1'b1);

    do_op(16'h0000, 16'h0000, 1'b1, 1, rs, rc, re, lat);
    chk("d3_sum", rs, 16'h0001);
    chk("d3_cout", rc, 1'b0);

    do_op(16'h000A, 16'h0000, 1'b0, 0, rs, rc, re, lat);
    chk("d4_err", re, ERR_EXP);

    do_op(16'h0009, 16'h0000, 1'b0, 0, rs, rc, re, lat);
    chk("d5_err", re, 1'b0);
    chk("d5_sum", rs, 16'h0009);

    // Reset during the second ADD cycle abandons the operation
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_cout", cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abandoned_no_valid", out_valid, 1'b0);
    end
    do_op(16'h0500, 16'h0500, 1'b0, 0, rs, rc, re, lat);
    chk("post_rst_sum", rs, 16'h1000);
    chk("post_rst_cout", rc, 1'b0);

    // Randomized operations with an independent decimal cross-check
    for (int n = 0; n < 40; n++) begin
      ta  = rnd_bcd($urandom_range(0, 7) == 0);
      tb_ = rnd_bcd($urandom_range(0, 7) == 0);
      tc  = 1'($urandom);
      do_op(ta, tb_, tc, $urandom_range(0, 3), rs, rc, re, lat);
      chk("rnd_latency", lat, DIGITS + 1);
      if (is_bcd(ta) && is_bcd(tb_)) begin
        de = to_dec(ta) + to_dec(tb_) + longint'(tc);
        chk("rnd_dec_sum", to_dec(rs), de % 10000);
        chk("rnd_dec_cout", rc, (de >= 10000));
        chk("rnd_err_valid", re, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
